// File: rtl/uart_receive.sv
// UART receiver: start bit, D_WIDTH data bits LSB first, one stop bit, idle-high line.
// Good words appear on a valid/ready port; framing errors and overruns pulse for one cycle.
module uart_receive #(
  parameter int D_WIDTH      = 13,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               overrun,
  output logic               rx_busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW   = $clog2(D_WIDTH + 1);

  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(D_WIDTH - 1);

  typedef enum logic [2:0] {
    WAIT_HI,
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_HI;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // The shift register is pure datapath; its content is only used after a full frame.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      WAIT_HI: begin
        if (rx) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (!rx) begin
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = CNT_BIT;
            idx_d   = '0;
          end else begin
            state_d = START;
            cnt_d   = CNT_HALF;
          end
        end
      end

      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx) begin
          state_d = DATA;
          cnt_d   = CNT_BIT;
          idx_d   = '0;
        end else begin
          // Start bit gone by mid-bit: treat as a glitch.
          state_d = IDLE;
        end
      end

      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d              = shift_q >> 1;
          shift_d[D_WIDTH-1]   = rx;
          idx_d                = idx_q + IW'(1);
          cnt_d                = CNT_BIT;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx) begin
          ferr_d  = 1'b1;
          state_d = WAIT_HI;
        end else if (!valid_q || rx_ready) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          ovr_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = WAIT_HI;
      end
    endcase

    // Registered so that busy reads 0 straight out of reset while the FSM sits in WAIT_HI.
    busy_d = (state_d != IDLE);
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: one instance at 1 clock/bit, one at 4 clocks/bit.
module tb_uart_receive;

  logic        clk;
  logic        rst;
  logic        rx0, rx_ready0;
  logic [12:0] rx_data0;
  logic        rx_valid0, frame_err0, overrun0, rx_busy0;
  logic        rx4, rx_ready4;
  logic [12:0] rx_data4;
  logic        rx_valid4, frame_err4, overrun4, rx_busy4;

  int checks = 0;
  int errors = 0;

  uart_receive #(.D_WIDTH(13), .CLKS_PER_BIT(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .frame_err(frame_err0), .overrun(overrun0), .rx_busy(rx_busy0)
  );

  uart_receive #(.D_WIDTH(13), .CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst(rst), .rx(rx4),
    .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_ready(rx_ready4),
    .frame_err(frame_err4), .overrun(overrun4), .rx_busy(rx_busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame at 1 clock/bit; rdy is applied on the stop-sample edge.
  task automatic send0(input logic [12:0] w, input logic stopb, input logic rdy);
    rx0 = 1'b0;
    step();
    for (int i = 0; i < 13; i++) begin
      rx0 = w[i];
      step();
    end
    rx0       = stopb;
    rx_ready0 = rdy;
    step();
  endtask

  // Line level for clock n of a 4-clock/bit frame; corrupt inverts every clock but the bit center.
  function automatic logic bit4(input logic [12:0] w, input int n, input logic corrupt);
    logic b;
    if (n < 4) return 1'b0;
    if (n >= 56) return 1'b1;
    b = w[(n - 4) / 4];
    if (corrupt && (((n - 4) % 4) != 1)) return ~b;
    return b;
  endfunction

  logic [12:0] w;
  logic [12:0] lb_prev;

  initial begin
    rst = 1'b1; rx0 = 1'b1; rx4 = 1'b1; rx_ready0 = 1'b0; rx_ready4 = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_data", rx_data0, 13'h0);
    chk("reset_valid", rx_valid0, 1'b0);
    chk("reset_ferr", frame_err0, 1'b0);
    chk("reset_ovr", overrun0, 1'b0);
    chk("reset_busy", rx_busy0, 1'b0);

    // Good frame 13'h1A5B, latency 14 edges from start edge
    for (int i = 0; i < 3; i++) step();
    w = 13'h1A5B;
    rx0 = 1'b0;
    step();
    for (int i = 0; i < 13; i++) begin
      rx0 = w[i];
      step();
    end
    chk("good_pre_stop_valid", rx_valid0, 1'b0);
    chk("good_busy", rx_busy0, 1'b1);
    rx0 = 1'b1;
    step();
    chk("good_valid", rx_valid0, 1'b1);
    chk("good_data", rx_data0, 13'h1A5B);
    chk("good_idle", rx_busy0, 1'b0);
    step();
    chk("good_hold_data", rx_data0, 13'h1A5B);
    rx_ready0 = 1'b1;
    step();
    rx_ready0 = 1'b0;
    chk("good_consumed", rx_valid0, 1'b0);

    // Framing error, line held low afterwards
    send0(13'h1A5B, 1'b0, 1'b0);
    chk("ferr_pulse", frame_err0, 1'b1);
    chk("ferr_no_valid", rx_valid0, 1'b0);
    chk("ferr_busy", rx_busy0, 1'b1);
    chk("ferr_no_ovr", overrun0, 1'b0);
    step();
    chk("ferr_one_cycle", frame_err0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("ferr_low_busy", rx_busy0, 1'b1);
    chk("ferr_low_no_valid", rx_valid0, 1'b0);
    chk("ferr_low_no_ferr", frame_err0, 1'b0);
    rx0 = 1'b1;
    step();
    chk("ferr_recover_idle", rx_busy0, 1'b0);
    send0(13'h0123, 1'b1, 1'b0);
    chk("ferr_next_valid", rx_valid0, 1'b1);
    chk("ferr_next_data", rx_data0, 13'h0123);
    rx_ready0 = 1'b1;
    step();
    rx_ready0 = 1'b0;
    chk("ferr_next_consumed", rx_valid0, 1'b0);

    // Overrun: back-to-back frames with the output full
    send0(13'h0001, 1'b1, 1'b0);
    chk("ovr_first_valid", rx_valid0, 1'b1);
    chk("ovr_first_data", rx_data0, 13'h0001);
    send0(13'h1FFF, 1'b1, 1'b0);
    chk("ovr_pulse", overrun0, 1'b1);
    chk("ovr_keep_data", rx_data0, 13'h0001);
    chk("ovr_keep_valid", rx_valid0, 1'b1);
    chk("ovr_no_ferr", frame_err0, 1'b0);
    step();
    chk("ovr_one_cycle", overrun0, 1'b0);
    rx_ready0 = 1'b1;
    step();
    rx_ready0 = 1'b0;
    chk("ovr_consumed", rx_valid0, 1'b0);

    // Same pair, consumer ready on the second stop sample
    send0(13'h0001, 1'b1, 1'b0);
    send0(13'h1FFF, 1'b1, 1'b1);
    chk("swap_data", rx_data0, 13'h1FFF);
    chk("swap_valid", rx_valid0, 1'b1);
    chk("swap_no_ovr", overrun0, 1'b0);
    step();
    rx_ready0 = 1'b0;
    chk("swap_consumed", rx_valid0, 1'b0);

    // 4 clocks/bit: one-clock glitch
    rx4 = 1'b0;
    step();
    rx4 = 1'b1;
    step();
    chk("glitch_idle", rx_busy4, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk("glitch_no_valid", rx_valid4, 1'b0);
    chk("glitch_no_ferr", frame_err4, 1'b0);
    chk("glitch_no_ovr", overrun4, 1'b0);

    // 4 clocks/bit frames: clean, then wrong everywhere but the bit centers
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 60; n++) begin
        rx4 = bit4(13'h0AAA, n, c[0]);
        step();
        if (n == 56) chk("os_pre_stop_valid", rx_valid4, 1'b0);
        if (n == 57) begin
          chk("os_valid", rx_valid4, 1'b1);
          chk("os_data", rx_data4, 13'h0AAA);
          chk("os_no_ferr", frame_err4, 1'b0);
        end
      end
      rx_ready4 = 1'b1;
      step();
      rx_ready4 = 1'b0;
      chk("os_consumed", rx_valid4, 1'b0);
    end

    // Reset during data bit 6 with the line low, output holding a word
    send0(13'h0555, 1'b1, 1'b0);
    chk("mid_pre_valid", rx_valid0, 1'b1);
    w = 13'h1FFF;
    rx0 = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      rx0 = w[i];
      step();
    end
    rx0 = 1'b0;
    rst = 1'b1;
    rx_ready0 = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_data", rx_data0, 13'h0);
    chk("mid_rst_valid", rx_valid0, 1'b0);
    chk("mid_rst_ferr", frame_err0, 1'b0);
    chk("mid_rst_ovr", overrun0, 1'b0);
    chk("mid_rst_busy", rx_busy0, 1'b0);
    for (int i = 0; i < 16; i++) step();
    chk("mid_low_no_valid", rx_valid0, 1'b0);
    chk("mid_low_busy", rx_busy0, 1'b1);
    chk("mid_low_no_ferr", frame_err0, 1'b0);
    rx0 = 1'b1;
    step();
    chk("mid_high_idle", rx_busy0, 1'b0);
    send0(13'h1234, 1'b1, 1'b0);
    chk("mid_next_valid", rx_valid0, 1'b1);
    chk("mid_next_data", rx_data0, 13'h1234);
    rx_ready0 = 1'b1;
    step();
    chk("mid_next_consumed", rx_valid0, 1'b0);

    // Loopback: 100 random words back-to-back, consumer always ready
    lb_prev = 13'h0;
    for (int k = 0; k < 100; k++) begin
      w = 13'($urandom_range(0, 8191));
      send0(w, 1'b1, 1'b1);
      chk("lb_valid", rx_valid0, 1'b1);
      chk("lb_data", rx_data0, w);
      chk("lb_no_ferr", frame_err0, 1'b0);
      chk("lb_no_ovr", overrun0, 1'b0);
      lb_prev = w;
    end
    step();
    chk("lb_last_consumed", rx_valid0, 1'b0);
    chk("lb_last_data_held", rx_data0, lb_prev);
    rx_ready0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
